line_cmd_ctrl: RTL
==================

// Module: line_cmd_ctrl
// PURPOSE
//   MMIO command front-end and scheduler for the line-drawing engine. CPU stores
//   stage a line (color, endpoints, frame base) and commit it into a command FIFO.
//   A dispatcher pops commands one at a time to the engine (valid/ready) and holds
//   off the next until the engine's done pulse. Status exposes busy/occupancy/overflow.
// PARAMETERS
//   DEPTH   4   command FIFO entries (power of 2, >=2)
//   CW      3   count width = log2(DEPTH)+1
// PORTS
//   clk        in   1   system clock, all logic on posedge
//   rst        in   1   synchronous reset, ACTIVE-LOW (rst==0 resets)
//   mmio_we    in   1   CPU write strobe, one word per cycle
//   mmio_re    in   1   CPU read strobe
//   mmio_addr  in   4   word offset in block (byte addr [5:2])
//   mmio_wdata in   32  write data
//   mmio_rdata out  32  read data, valid the cycle after mmio_re
//   le_valid   out  1   command valid to line engine
//   le_ready   in   1   engine accepts command when le_valid&le_ready
//   le_color   out  32  pixel color
//   le_x0/le_y0 out 10  start point;  le_x1/le_y1 out 10  end point
//   le_fb_base out  32  frame buffer base address
//   le_done    in   1   one-cycle pulse: engine finished current line
//   irq        out  1   level: FIFO empty and dispatcher idle and IRQ_EN
// BEHAVIOUR
//   Registers (word offset): 0 COLOR(rw), 1 START(rw {x0[25:16],y0[9:0]}),
//     2 END(rw {x1[25:16],y1[9:0]}), 3 FBBASE(rw), 4 COMMIT(wo, any data),
//     5 STATUS(ro/w1c), 6 CTRL(rw bit0 IRQ_EN). Unused/undefined bits read 0.
//   STATUS = {.., ovf[8], cnt[CW-1+4:4], full[2], empty[1], busy[0]}.
//     busy = dispatcher not IDLE. Write to 5 with bit8=1 clears ovf.
//   COMMIT: pushes {COLOR,START,END,FBBASE} snapshot of that cycle's staged regs.
//     FIFO full -> command dropped, ovf<=1 (sticky). Staged regs unchanged by commit.
//   Same-cycle write to staged reg and COMMIT impossible (one write/cycle).
//   Dispatcher FSM:
//     IDLE  : FIFO non-empty -> pop head into le_* regs, go ISSUE.
//     ISSUE : le_valid=1, le_* stable; le_ready=1 -> go BUSY (le_valid 0 next).
//     BUSY  : wait le_done -> IDLE. le_done in IDLE/ISSUE ignored.
//   Latency: COMMIT at cycle N into empty FIFO+IDLE -> le_valid high at N+2.
//   Back-to-back: le_done at cycle M, FIFO non-empty -> next le_valid at M+2.
//   Simultaneous COMMIT and pop on full FIFO: pop has priority view of cycle start
//     state -> FIFO full at cycle start means COMMIT dropped (no pass-through).
//   cnt counts FIFO entries only (not the in-flight command). Pointers wrap mod DEPTH.
//   Reset (rst==0): FIFO empty, FSM IDLE, le_valid=0, le_* data=0, staged regs=0,
//     ovf=0, IRQ_EN=0, irq=0, mmio_rdata=0. Reset mid-ISSUE/BUSY abandons command;
//     engine is reset by the same rst.
// TESTING
//   1. Write COLOR=0x00FF, START=0x0000_0000, END=0x012C_0258, FBBASE=0x1040_0000, COMMIT
//      -> 2 cycles later le_valid=1, le_x1=300, le_y1=600, le_color=0xFF, le_fb_base=0x10400000.
//   2. Hold le_ready=0 for 5 cycles -> le_valid and le_* stable; STATUS.busy=1 throughout.
//   3. COMMIT 5 lines with engine stalled (DEPTH=4) -> 1 in flight, cnt=4... 5th gets
//      accepted only if first popped; 6th COMMIT sets ovf=1, STATUS reads 0x1_45 pattern
//      (ovf,cnt=4,full); write STATUS bit8 -> ovf=0.
//   4. Queue 3 lines, pulse le_done each time ready -> commands issued in order, each
//      le_valid 2 cycles after prior le_done; end with empty=1, busy=0.
//   5. CTRL=1, drain queue -> irq rises the cycle FSM returns IDLE with empty FIFO.
//   6. Assert rst=0 during BUSY with 2 queued -> next cycle le_valid=0, cnt=0, STATUS=0x2.

Source files
------------

// File: rtl/line_cmd_if.sv
// Bus bundle between the line command controller, the CPU MMIO port and the line engine.
// The master modport is the CPU/engine side; the slave modport is the controller.
interface line_cmd_if;
  logic        mmio_we;
  logic        mmio_re;
  logic [3:0]  mmio_addr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;
  logic        le_valid;
  logic        le_ready;
  logic [31:0] le_color;
  logic [9:0]  le_x0;
  logic [9:0]  le_y0;
  logic [9:0]  le_x1;
  logic [9:0]  le_y1;
  logic [31:0] le_fb_base;
  logic        le_done;
  logic        irq;

  modport master (
    output mmio_we, mmio_re, mmio_addr, mmio_wdata, le_ready, le_done,
    input  mmio_rdata, le_valid, le_color, le_x0, le_y0, le_x1, le_y1, le_fb_base, irq
  );

  modport slave (
    input  mmio_we, mmio_re, mmio_addr, mmio_wdata, le_ready, le_done,
    output mmio_rdata, le_valid, le_color, le_x0, le_y0, le_x1, le_y1, le_fb_base, irq
  );
endinterface

// File: rtl/line_cmd_ctrl.sv
// MMIO staging registers, command FIFO and one-at-a-time dispatcher for the line engine.
// Commands are issued with valid/ready and the next one waits for the engine's done pulse.
module line_cmd_ctrl #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic     clk,
    input logic     rst,
    line_cmd_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] color;
        logic [9:0]  x0;
        logic [9:0]  y0;
        logic [9:0]  x1;
        logic [9:0]  y1;
        logic [31:0] fb_base;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    typedef enum logic [3:0] {
        A_COLOR  = 4'd0,
        A_START  = 4'd1,
        A_END    = 4'd2,
        A_FBBASE = 4'd3,
        A_COMMIT = 4'd4,
        A_STATUS = 4'd5,
        A_CTRL   = 4'd6
    } addr_t;

    cmd_t          stage;
    cmd_t          le_cmd;
    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          irq_en;
    logic [31:0]   rdata;
    logic [31:0]   rd_word;
    logic [31:0]   status_word;
    state_t        state;
    state_t        state_d;
    logic          pop;
    logic          full;
    logic          empty;
    logic          commit;
    logic          push;

    assign full   = (cnt == CW'(DEPTH));
    assign empty  = (cnt == '0);
    assign commit = bus.mmio_we && (bus.mmio_addr == A_COMMIT);
    // Fullness is judged on the cycle-start count, so a pop in the same cycle never rescues a commit.
    assign push   = commit && !full;

    // NOTE: the FSM next-state block assigns every output a default first so no latch is inferred.
    always_comb begin
        state_d = state;
        pop     = 1'b0;
        case (state)
            IDLE:  if (!empty) begin
                       pop     = 1'b1;
                       state_d = ISSUE;
                   end
            ISSUE: if (bus.le_ready) state_d = BUSY;
            BUSY:  if (bus.le_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            le_cmd <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            state <= state_d;
            if (pop) begin
                le_cmd <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // NOTE: FIFO storage carries no reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= stage;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage  <= '0;
            ovf    <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            if (bus.mmio_we) begin
                case (bus.mmio_addr)
                    A_COLOR:  stage.color   <= bus.mmio_wdata;
                    A_START:  begin
                                  stage.x0 <= bus.mmio_wdata[25:16];
                                  stage.y0 <= bus.mmio_wdata[9:0];
                              end
                    A_END:    begin
                                  stage.x1 <= bus.mmio_wdata[25:16];
                                  stage.y1 <= bus.mmio_wdata[9:0];
                              end
                    A_FBBASE: stage.fb_base <= bus.mmio_wdata;
                    A_STATUS: if (bus.mmio_wdata[8]) ovf <= 1'b0;
                    A_CTRL:   irq_en <= bus.mmio_wdata[0];
                    default:  ;
                endcase
            end
            if (commit && full) ovf <= 1'b1;
        end
    end

    always_comb begin
        status_word            = '0;
        status_word[0]         = (state != IDLE);
        status_word[1]         = empty;
        status_word[2]         = full;
        status_word[CW+3:4]    = cnt;
        status_word[8]         = ovf;
    end

    always_comb begin
        rd_word = '0;
        case (bus.mmio_addr)
            A_COLOR:  rd_word = stage.color;
            A_START:  rd_word = {6'd0, stage.x0, 6'd0, stage.y0};
            A_END:    rd_word = {6'd0, stage.x1, 6'd0, stage.y1};
            A_FBBASE: rd_word = stage.fb_base;
            A_STATUS: rd_word = status_word;
            A_CTRL:   rd_word = {31'd0, irq_en};
            default:  rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)             rdata <= '0;
        else if (bus.mmio_re) rdata <= rd_word;
    end

    assign bus.mmio_rdata = rdata;
    assign bus.le_valid   = (state == ISSUE);
    assign bus.le_color   = le_cmd.color;
    assign bus.le_x0      = le_cmd.x0;
    assign bus.le_y0      = le_cmd.y0;
    assign bus.le_x1      = le_cmd.x1;
    assign bus.le_y1      = le_cmd.y1;
    assign bus.le_fb_base = le_cmd.fb_base;
    assign bus.irq        = irq_en && empty && (state == IDLE);

endmodule
